line_buffer_3row: RTL and testbench

Raster-to-column converter that feeds the 3x3 window shift register. It accepts one pixel per cycle in raster order and keeps the two previous image rows in on-chip line memories. For every accepted pixel from row 2 onward it emits one vertically aligned three-pixel column (rows y-2, y-1, y) with a column-valid strobe. The block sits between the grayscale pixel source and the 3x3 window / averaging filter stage.

---
 rtl/line_buffer_3row.sv | 173 +++++++++++++++++
 tb/tb_line_buffer_3row.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/line_buffer_3row.sv
// ----------------------------------------------------------------------------
// line_buffer_3row
// Raster-to-column converter for the 3x3 window stage. Accepts one pixel per
// cycle in raster order, keeps the two previous rows in line memories and,
// from image row 2 onward, emits one vertical three-pixel column per accepted
// pixel, one cycle after it was accepted.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   in_valid           in_pixel / in_sof valid this cycle (no backpressure)
//   in_sof             with in_valid: this pixel is (x=0, y=0)
//   in_pixel           incoming raster pixel
//   col_valid          single-cycle strobe: new column on row0..row2_out
//   row0_out           pixel (x, y-2), oldest row
//   row1_out           pixel (x, y-1)
//   row2_out           pixel (x, y), newest row
//   col_eol            with col_valid: column is the last of its row
//   col_eof            with col_valid: column is the last of the frame
// ----------------------------------------------------------------------------
module line_buffer_3row #(
    parameter int unsigned PIXEL_SIZE = 8,
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic                  in_sof,
    input  logic [PIXEL_SIZE-1:0] in_pixel,
    output logic                  col_valid,
    output logic [PIXEL_SIZE-1:0] row0_out,
    output logic [PIXEL_SIZE-1:0] row1_out,
    output logic [PIXEL_SIZE-1:0] row2_out,
    output logic                  col_eol,
    output logic                  col_eof
);

    localparam int unsigned XW = $clog2(IMG_WIDTH);
    localparam int unsigned YW = $clog2(IMG_HEIGHT);

    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
    localparam logic [YW-1:0] Y_ONE  = YW'(1);

    typedef enum logic {
        S_FILL = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [XW-1:0]           x_q, x_d;
    logic [YW-1:0]           y_q, y_d;
    logic                    col_valid_q, col_valid_d;
    logic [PIXEL_SIZE-1:0]   row0_q, row0_d;
    logic [PIXEL_SIZE-1:0]   row1_q, row1_d;
    logic [PIXEL_SIZE-1:0]   row2_q, row2_d;
    logic                    col_eol_q, col_eol_d;
    logic                    col_eof_q, col_eof_d;

    // Effective position of the pixel on in_pixel (sof overrides the counters)
    logic [XW-1:0]           cur_x;
    logic [YW-1:0]           cur_y;
    logic                    last_x;
    logic                    last_y;
    logic                    mem_we;

    // Line memories: mem_a holds row y-2, mem_b holds row y-1 (not reset)
    logic [PIXEL_SIZE-1:0]   mem_a [IMG_WIDTH];
    logic [PIXEL_SIZE-1:0]   mem_b [IMG_WIDTH];

    // Position, next-state and output computation
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        col_valid_d = 1'b0;
        row0_d      = row0_q;
        row1_d      = row1_q;
        row2_d      = row2_q;
        col_eol_d   = col_eol_q;
        col_eof_d   = col_eof_q;
        mem_we      = 1'b0;
        cur_x       = x_q;
        cur_y       = y_q;

        if (in_valid && in_sof) begin
            cur_x = '0;
            cur_y = '0;
        end

        last_x = (cur_x == X_LAST);
        last_y = (cur_y == Y_LAST);

        if (in_valid) begin
            mem_we = 1'b1;

            // Raster advance; wraps to (0,0) after the last pixel of the frame
            if (last_x) begin
                x_d = '0;
                y_d = last_y ? '0 : cur_y + YW'(1);
            end else begin
                x_d = cur_x + XW'(1);
                y_d = cur_y;
            end

            if (in_sof) begin
                // A start-of-frame pixel restarts row fill and emits nothing
                state_d = S_FILL;
            end else begin
                unique case (state_q)
                    S_FILL: begin
                        if (last_x && (cur_y == Y_ONE)) begin
                            state_d = S_RUN;
                        end
                    end
                    S_RUN: begin
                        col_valid_d = 1'b1;
                        row0_d      = mem_a[cur_x];
                        row1_d      = mem_b[cur_x];
                        row2_d      = in_pixel;
                        col_eol_d   = last_x;
                        col_eof_d   = last_x && last_y;
                        if (last_x && last_y) begin
                            state_d = S_FILL;
                        end
                    end
                    default: state_d = S_FILL;
                endcase
            end
        end
    end

    // Control and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FILL;
            x_q         <= '0;
            y_q         <= '0;
            col_valid_q <= 1'b0;
            row0_q      <= '0;
            row1_q      <= '0;
            row2_q      <= '0;
            col_eol_q   <= 1'b0;
            col_eof_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            col_valid_q <= col_valid_d;
            row0_q      <= row0_d;
            row1_q      <= row1_d;
            row2_q      <= row2_d;
            col_eol_q   <= col_eol_d;
            col_eof_q   <= col_eof_d;
        end
    end

    // Row shift through the line memories; reads above see pre-write contents
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_a[cur_x] <= mem_b[cur_x];
            mem_b[cur_x] <= in_pixel;
        end
    end

    assign col_valid = col_valid_q;
    assign row0_out  = row0_q;
    assign row1_out  = row1_q;
    assign row2_out  = row2_q;
    assign col_eol   = col_eol_q;
    assign col_eof   = col_eof_q;

endmodule

// File: tb/tb_line_buffer_3row.sv
// ----------------------------------------------------------------------------
// tb_line_buffer_3row
// Self-checking bench for line_buffer_3row (4x4 image). A reference model keeps
// the current frame as a 2-D image and derives every expected column from the
// pixels stored at rows y-2 and y-1; directed frames are followed by random
// valid/sof/pixel traffic.
// ----------------------------------------------------------------------------
module tb_line_buffer_3row;

    localparam int unsigned P = 8;
    localparam int unsigned W = 4;
    localparam int unsigned H = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_sof;
    logic [P-1:0] in_pixel;
    logic         col_valid;
    logic [P-1:0] row0_out;
    logic [P-1:0] row1_out;
    logic [P-1:0] row2_out;
    logic         col_eol;
    logic         col_eof;

    line_buffer_3row #(
        .PIXEL_SIZE (P),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_pixel  (in_pixel),
        .col_valid (col_valid),
        .row0_out  (row0_out),
        .row1_out  (row1_out),
        .row2_out  (row2_out),
        .col_eol   (col_eol),
        .col_eof   (col_eof)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cols_seen = 0;

    // Reference model: current frame image and raster position
    int           img [H][W];
    int           mx;
    int           my;
    logic         e_valid;
    logic [P-1:0] e_r0, e_r1, e_r2;
    logic         e_eol, e_eof;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mx      = 0;
        my      = 0;
        e_valid = 1'b0;
        e_r0    = '0;
        e_r1    = '0;
        e_r2    = '0;
        e_eol   = 1'b0;
        e_eof   = 1'b0;
    endtask

    task automatic check_outputs();
        check_eq("col_valid", 32'(col_valid), 32'(e_valid));
        check_eq("row0_out",  32'(row0_out),  32'(e_r0));
        check_eq("row1_out",  32'(row1_out),  32'(e_r1));
        check_eq("row2_out",  32'(row2_out),  32'(e_r2));
        check_eq("col_eol",   32'(col_eol),   32'(e_eol));
        check_eq("col_eof",   32'(col_eof),   32'(e_eof));
    endtask

    // Drive one cycle (starting just after a rising edge), update the model,
    // then check the registered outputs just after the next rising edge.
    task automatic step(input logic v, input logic s, input logic [P-1:0] p);
        in_valid = v;
        in_sof   = s;
        in_pixel = p;
        e_valid  = 1'b0;
        if (v) begin
            if (s) begin
                mx = 0;
                my = 0;
            end
            img[my][mx] = int'(p);
            if (my >= 2 && !s) begin
                e_valid = 1'b1;
                e_r0    = P'(img[my-2][mx]);
                e_r1    = P'(img[my-1][mx]);
                e_r2    = p;
                e_eol   = (mx == W - 1);
                e_eof   = (mx == W - 1) && (my == H - 1);
            end
            if (mx == W - 1) begin
                mx = 0;
                my = (my == H - 1) ? 0 : my + 1;
            end else begin
                mx = mx + 1;
            end
        end
        @(posedge clk);
        #1;
        if (col_valid) cols_seen++;
        check_outputs();
    endtask

    // One frame with pixel = base + 16*y + x; gap_mode inserts the 1,0,0,1 pattern
    task automatic send_frame(input int base, input logic sof_first, input logic gap_mode);
        int phase;
        phase = 0;
        for (int y = 0; y < int'(H); y++) begin
            for (int x = 0; x < int'(W); x++) begin
                if (gap_mode) begin
                    while ((phase % 4) == 1 || (phase % 4) == 2) begin
                        step(1'b0, 1'b0, P'($urandom));
                        phase++;
                    end
                    phase++;
                end
                step(1'b1, sof_first && x == 0 && y == 0, P'(base + 16 * y + x));
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_pixel = '0;
        model_reset();

        // Reset held with random inputs: every output stays 0
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'(($urandom));
            in_sof   = 1'(($urandom));
            in_pixel = P'($urandom);
            check_outputs();
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // First frame without sof: rows 0-1 silent, then 8 columns
        cols_seen = 0;
        for (int y = 0; y < int'(H); y++) begin
            for (int x = 0; x < int'(W); x++) begin
                step(1'b1, 1'b0, P'(16 * y + x));
                if (y == 1 && x == int'(W) - 1) check_eq("fill_no_cols", 32'(cols_seen), 32'd0);
                if (y == 2 && x == 0) begin
                    check_eq("first_r0", 32'(row0_out), 32'h00);
                    check_eq("first_r1", 32'(row1_out), 32'h10);
                    check_eq("first_r2", 32'(row2_out), 32'h20);
                end
            end
        end
        check_eq("last_r0", 32'(row0_out), 32'h13);
        check_eq("last_r1", 32'(row1_out), 32'h23);
        check_eq("last_r2", 32'(row2_out), 32'h33);
        check_eq("last_eof", 32'(col_eof), 32'd1);
        check_eq("frame_cols", 32'(cols_seen), 32'd8);

        // Gapped frame with sof on the first pixel
        cols_seen = 0;
        send_frame(0, 1'b1, 1'b1);
        check_eq("gap_cols", 32'(cols_seen), 32'd8);

        // Back-to-back frames, second one entered by counter wrap only
        cols_seen = 0;
        send_frame(0, 1'b1, 1'b0);
        for (int y = 0; y < int'(H); y++) begin
            for (int x = 0; x < int'(W); x++) begin
                step(1'b1, 1'b0, P'(8'h80 + 16 * y + x));
                if (y == 2 && x == 0) begin
                    check_eq("b2b_r0", 32'(row0_out), 32'h80);
                    check_eq("b2b_r1", 32'(row1_out), 32'h90);
                    check_eq("b2b_r2", 32'(row2_out), 32'hA0);
                end
            end
        end
        check_eq("b2b_cols", 32'(cols_seen), 32'd16);

        // Mid-frame sof at (2,2): old frame aborted, new frame refills
        for (int y = 0; y < 3; y++) begin
            for (int x = 0; x < int'(W); x++) begin
                if (!(y == 2 && x >= 2)) step(1'b1, 1'b0, P'(16 * y + x));
            end
        end
        cols_seen = 0;
        send_frame(8'h40, 1'b1, 1'b0);
        check_eq("sof_cols", 32'(cols_seen), 32'd8);

        // Async reset during RUN right after pixel (1,3)
        for (int y = 0; y < int'(H); y++) begin
            for (int x = 0; x < int'(W); x++) begin
                if (y < 3 || x < 2) step(1'b1, y == 0 && x == 0, P'(16 * y + x));
            end
        end
        check_eq("pre_rst_valid", 32'(col_valid), 32'd1);
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int y = 0; y < int'(H); y++) begin
            for (int x = 0; x < int'(W); x++) begin
                step(1'b1, 1'b0, P'(16 * y + x));
                if (y == 2 && x == 0) begin
                    check_eq("rst_r0", 32'(row0_out), 32'h00);
                    check_eq("rst_r1", 32'(row1_out), 32'h10);
                    check_eq("rst_r2", 32'(row2_out), 32'h20);
                end
            end
        end

        // Random traffic: random gaps, rare sof, sof without valid
        for (int i = 0; i < 3000; i++) begin
            logic v;
            logic s;
            v = ($urandom_range(0, 9) < 7);
            s = ($urandom_range(0, 39) == 0);
            step(v, s, P'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
